// File: rtl/psi_pkg.sv
// Shared definitions for the PSI match-scan stage: scan FSM states,
// the padding sentinel and width helpers for index/count registers.
package psi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    // Widest element the sentinel helper can produce.
    localparam int PAD_MAX_W = 1024;

    // Padding sentinel: all-ones of width w, right-aligned.
    function automatic logic [PAD_MAX_W-1:0] pad_sentinel(input int unsigned w);
        return {PAD_MAX_W{1'b1}} >> (PAD_MAX_W - w);
    endfunction

    // Index register width: one extra bit so idx can reach K without wrapping.
    function automatic int idx_width(input int k);
        return $clog2(k) + 1;
    endfunction

    // Match counter width.
    function automatic int count_width(input int k);
        return $clog2(k);
    endfunction

endpackage

// File: rtl/psi_match_scan_if.sv
// Handshake bundle of the match-scan stage: sorted-array input side and
// intersection-element output side, plus completion status.
interface psi_match_scan_if #(
    parameter int W = 32,
    parameter int K = 16
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [W*K-1:0]         in_array;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_data;
    logic                   done;
    logic [$clog2(K)-1:0]   match_count;

    modport master (
        output in_valid, in_array, out_ready,
        input  in_ready, out_valid, out_data, done, match_count
    );

    modport slave (
        input  in_valid, in_array, out_ready,
        output in_ready, out_valid, out_data, done, match_count
    );
endinterface

// File: rtl/psi_eq_cmp.sv
// W-bit equality compare for one adjacent pair of sorted elements.
// Optional feature macro: PSI_SCAN_PAD_FILTER_EN -- when defined, a pair
// equal to the all-ones padding sentinel never counts as a match.
module psi_eq_cmp
    import psi_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);
`ifdef PSI_SCAN_PAD_FILTER_EN
    localparam logic [W-1:0] PAD = W'(pad_sentinel(W));

    assign eq = (a == b) && (a != PAD);
`else
    assign eq = (a == b);
`endif
endmodule

// File: rtl/psi_match_scan.sv
// PSI match scan: captures one sorted array of K elements, walks adjacent
// pairs one per cycle and streams out every duplicated value (intersection
// element) over valid/ready, then pulses done.
// Optional feature macro: PSI_SCAN_PAD_FILTER_EN (see psi_eq_cmp).
module psi_match_scan
    import psi_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 16
) (
    input  logic           clk,
    input  logic           rst,
    psi_match_scan_if.slave bus
);
    localparam int AW = $clog2(K);
    localparam int IW = idx_width(K);
    localparam int CW = count_width(K);
    localparam logic [IW-1:0] LAST = IW'(K - 2);

    scan_state_t   state_q, state_d;
    logic [W-1:0]  arr_q [K];
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          done_q, done_d;

    logic [IW-1:0] idx_p1, idx_p2;
    logic [W-1:0]  cur_elem, nxt_elem;
    logic          pair_eq;
    logic          capture;

    assign capture  = (state_q == IDLE) && bus.in_valid;
    assign idx_p1   = idx_q + IW'(1);
    assign idx_p2   = idx_q + IW'(2);
    // In SCAN idx <= K-2, so both selects stay inside the buffer.
    assign cur_elem = arr_q[idx_q[AW-1:0]];
    assign nxt_elem = arr_q[AW'(idx_p1)];

    psi_eq_cmp #(.W(W)) u_eq (
        .a  (cur_elem),
        .b  (nxt_elem),
        .eq (pair_eq)
    );

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.done        = done_q;
    assign bus.match_count = cnt_q;

    // Array buffer: loaded on capture only; contents are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < K; i++) begin
                arr_q[i] <= bus.in_array[i*W +: W];
            end
        end
    end

    // State, index, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output decode; done is raised on entry to DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (pair_eq) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cur_elem;
                    state_d     = EMIT;
                end else begin
                    idx_d = idx_p1;
                    if (idx_p1 > LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CW'(1);
                    // A value occurs at most twice, so the partner can be skipped.
                    idx_d       = idx_p2;
                    if (idx_p2 > LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_psi_match_scan.sv
// Directed bench for psi_match_scan with W=8, K=8.
module tb_psi_match_scan;
    localparam int W = 8;
    localparam int K = 8;

    logic clk;
    logic rst;

    psi_match_scan_if #(.W(W), .K(K)) bus ();

    psi_match_scan #(.W(W), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    int done_at;
    int stall_seen;
    int stall_bad;
    int busy_rdy;
    int dv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3,
                                          input logic [7:0] a4, input logic [7:0] a5,
                                          input logic [7:0] a6, input logic [7:0] a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Present an array during an IDLE cycle; returns at the negedge of the
    // first SCAN cycle.
    task automatic start(input logic [63:0] arr, input bit keep);
        bus.in_valid = 1'b1;
        bus.in_array = arr;
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Follow a scan from its first SCAN cycle (c=1) to the done cycle,
    // consuming outputs; the first 'stall' valid cycles are refused.
    task automatic scan(input int stall);
        int left;
        left = stall;
        got.delete();
        done_at = -1;
        stall_seen = 0;
        stall_bad = 0;
        busy_rdy = 0;
        dv = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.in_ready) busy_rdy++;
            if (bus.done) begin
                done_at = c;
                if (bus.out_valid) dv++;
                break;
            end
            if (bus.out_valid && left > 0) begin
                bus.out_ready = 1'b0;
                left--;
                stall_seen++;
                if (bus.out_data !== 8'd3) stall_bad++;
            end else begin
                bus.out_ready = 1'b1;
                if (bus.out_valid) got.push_back(bus.out_data);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic check_outs(input string tag, input int n,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e [3];
        logic [7:0] v;
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        chk({tag, "_n"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            v = (i < got.size()) ? got[i] : 8'hxx;
            chk($sformatf("%s_d%0d", tag, i), {24'd0, v}, {24'd0, e[i]});
        end
    endtask

    logic [63:0] arr_a, arr_b, arr_c, arr_d;

    initial begin
        arr_a = pack8(8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd8, 8'd9, 8'd10);
        arr_b = pack8(8'd1, 8'd3, 8'd3, 8'd4, 8'd6, 8'd6, 8'd9, 8'd9);
        arr_c = pack8(8'd2, 8'd2, 8'd4, 8'd4, 8'd5, 8'd6, 8'd7, 8'd7);
        arr_d = pack8(8'd4, 8'd5, 8'd6, 8'd7, 8'd255, 8'd255, 8'd255, 8'd255);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_array = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_count", bus.match_count, 0);

        // No matches: done at t0+8
        start(arr_a, 1'b0);
        scan(0);
        chk("nomatch_done_at", done_at, 8);
        chk("nomatch_count", bus.match_count, 0);
        check_outs("nomatch_out", 0, 8'd0, 8'd0, 8'd0);
        chk("nomatch_busy_rdy", busy_rdy, 0);
        @(negedge clk);
        chk("nomatch_done_pulse", bus.done, 0);
        chk("nomatch_idle_rdy", bus.in_ready, 1);

        // Three matches, consumer always ready
        start(arr_b, 1'b0);
        scan(0);
        chk("m3_done_at", done_at, 9);
        chk("m3_count", bus.match_count, 3);
        check_outs("m3_out", 3, 8'd3, 8'd6, 8'd9);
        chk("m3_done_vs_valid", dv, 0);
        @(negedge clk);

        // Same array, first match refused for 5 cycles
        start(arr_b, 1'b0);
        scan(5);
        chk("stall_done_at", done_at, 14);
        chk("stall_seen", stall_seen, 5);
        chk("stall_data_stable", stall_bad, 0);
        chk("stall_count", bus.match_count, 3);
        check_outs("stall_out", 3, 8'd3, 8'd6, 8'd9);
        @(negedge clk);

        // in_valid held with another array while busy
        start(arr_a, 1'b1);
        bus.in_array = arr_c;
        scan(0);
        chk("busy_done_at", done_at, 8);
        chk("busy_count", bus.match_count, 0);
        chk("busy_in_ready", busy_rdy, 0);
        check_outs("busy_out", 0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("after_done_rdy", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        scan(0);
        chk("second_done_at", done_at, 9);
        chk("second_count", bus.match_count, 3);
        check_outs("second_out", 3, 8'd2, 8'd4, 8'd7);
        @(negedge clk);

        // Reset during EMIT of the second match
        start(arr_b, 1'b0);
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b0;
        chk("emit_valid", bus.out_valid, 1);
        chk("emit_data", bus.out_data, 6);
        chk("emit_count", bus.match_count, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstemit_valid", bus.out_valid, 0);
        chk("rstemit_rdy", bus.in_ready, 1);
        chk("rstemit_count", bus.match_count, 0);
        chk("rstemit_done", bus.done, 0);
        chk("rstemit_data", bus.out_data, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        start(arr_c, 1'b0);
        scan(0);
        chk("postrst_done_at", done_at, 9);
        chk("postrst_count", bus.match_count, 3);
        check_outs("postrst_out", 3, 8'd2, 8'd4, 8'd7);
        @(negedge clk);

        // Padding sentinel pairs
        start(arr_d, 1'b0);
        scan(0);
`ifdef PSI_SCAN_PAD_FILTER_EN
        chk("pad_done_at", done_at, 8);
        chk("pad_count", bus.match_count, 0);
        check_outs("pad_out", 0, 8'd0, 8'd0, 8'd0);
`else
        chk("pad_done_at", done_at, 9);
        chk("pad_count", bus.match_count, 2);
        check_outs("pad_out", 2, 8'd255, 8'd255, 8'd0);
`endif
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
